// File: rtl/multiplier_issue_buffer.sv
// multiplier_issue_buffer: issues tagged operand pairs to a fixed-latency multiplier
// and collects product+tag in an in-order result FIFO guarded by a credit count.
module multiplier_issue_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int TAG_WIDTH  = 11,
    parameter int LATENCY    = 2,
    parameter int DEPTH      = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [DATA_WIDTH-1:0]        req_in0,
    input  logic [DATA_WIDTH-1:0]        req_in1,
    input  logic [TAG_WIDTH-1:0]         req_tag,
    output logic [DATA_WIDTH-1:0]        mul_in0,
    output logic [DATA_WIDTH-1:0]        mul_in1,
    output logic                         mul_valid_in,
    input  logic [DATA_WIDTH-1:0]        mul_out,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [DATA_WIDTH-1:0]        rsp_data,
    output logic [TAG_WIDTH-1:0]         rsp_tag,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
    localparam int OW = $clog2(DEPTH + 1);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [OW-1:0] FULL = OW'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic                  accept;
    logic                  fifo_wr;
    logic                  pop;
    logic [LATENCY-1:0]    vld_pipe;
    logic [TAG_WIDTH-1:0]  tag_pipe [LATENCY];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [TAG_WIDTH-1:0]  tag_mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [OW-1:0]         count;

    // Credits cover in-flight ops too, so a pop only frees a slot on the following cycle.
    assign req_ready    = !reset && occupancy < FULL;
    assign accept       = req_valid && req_ready;
    assign mul_in0      = req_in0;
    assign mul_in1      = req_in1;
    assign mul_valid_in = accept;
    assign fifo_wr      = vld_pipe[LATENCY-1];
    assign rsp_valid    = count != '0;
    assign pop          = rsp_valid && rsp_ready;
    assign rsp_data     = data_mem[rd_ptr];
    assign rsp_tag      = tag_mem[rd_ptr];

    // Tag/valid shadow the multiplier pipeline; no enable because the multiplier cannot stall.
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            vld_pipe <= '0;
            for (int i = 0; i < LATENCY; i++) tag_pipe[i] <= '0;
        end else begin
            vld_pipe[0] <= accept;
            tag_pipe[0] <= req_tag;
            for (int i = 1; i < LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            occupancy <= '0;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            occupancy <= occupancy + OW'(accept) - OW'(pop);
            count     <= count + OW'(fifo_wr) - OW'(pop);
            wr_ptr    <= fifo_wr ? (wr_ptr == LAST ? '0 : wr_ptr + 1'b1) : wr_ptr;
            rd_ptr    <= pop ? (rd_ptr == LAST ? '0 : rd_ptr + 1'b1) : rd_ptr;
        end

    always_ff @(posedge clock)
        if (fifo_wr) begin
            data_mem[wr_ptr] <= mul_out;
            tag_mem[wr_ptr]  <= tag_pipe[LATENCY-1];
        end

    assert property (@(posedge clock) disable iff (reset) !(fifo_wr && count == FULL));
    assert property (@(posedge clock) disable iff (reset) occupancy <= FULL);
endmodule

// File: tb/tb_multiplier_issue_buffer.sv
// tb_multiplier_issue_buffer: directed checks of multiplier_issue_buffer with a 2-cycle multiplier model.
module tb_multiplier_issue_buffer;
    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_in0;
    logic [15:0] req_in1;
    logic [10:0] req_tag;
    logic [15:0] mul_in0;
    logic [15:0] mul_in1;
    logic        mul_valid_in;
    logic [15:0] mul_out;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [10:0] rsp_tag;
    logic [2:0]  occupancy;
    logic [15:0] p1;
    logic [15:0] p2;
    logic [26:0] sb [$];
    logic [26:0] exp_rsp;
    int checks = 0;
    int errors = 0;
    int k;
    int issued;
    int popped;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        p1 <= 16'(mul_in0 * mul_in1);
        p2 <= p1;
    end
    assign mul_out = p2;

    multiplier_issue_buffer dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_in0(req_in0), .req_in1(req_in1), .req_tag(req_tag),
        .mul_in0(mul_in0), .mul_in1(mul_in1), .mul_valid_in(mul_valid_in), .mul_out(mul_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
        .occupancy(occupancy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_op();
        req_in0 = 16'(k * 7 + 3);
        req_in1 = 16'(k + 2);
        req_tag = 11'(k);
    endtask

    // Scoreboard step: record accepts, compare pops in order, then advance one cycle.
    task automatic sb_step(input string tag);
        if (req_valid && req_ready) begin
            sb.push_back({16'(req_in0 * req_in1), req_tag});
            issued++;
            k++;
        end
        if (rsp_valid && rsp_ready) begin
            chk({tag, "_nonempty"}, 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                exp_rsp = sb.pop_front();
                chk(tag, 32'({rsp_data, rsp_tag}), 32'(exp_rsp));
                popped++;
            end
        end
        tick();
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_in0 = '0; req_in1 = '0; req_tag = '0; rsp_ready = 1'b0;
        tick(); tick();
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_valid", 32'(rsp_valid), 0);
        chk("rst_occ", 32'(occupancy), 0);
        reset = 1'b0;
        tick();

        // 1: single op 3*5 tag 7
        rsp_ready = 1'b1; req_valid = 1'b1; req_in0 = 16'd3; req_in1 = 16'd5; req_tag = 11'd7;
        chk("t1_ready", 32'(req_ready), 1);
        tick();
        req_valid = 1'b0;
        chk("t1_occ_c1", 32'(occupancy), 1);
        chk("t1_idle_c1", 32'(rsp_valid), 0);
        tick();
        chk("t1_idle_c2", 32'(rsp_valid), 0);
        tick();
        chk("t1_valid_c3", 32'(rsp_valid), 1);
        chk("t1_data", 32'(rsp_data), 32'h000F);
        chk("t1_tag", 32'(rsp_tag), 7);
        tick();
        chk("t1_occ_c4", 32'(occupancy), 0);
        chk("t1_idle_c4", 32'(rsp_valid), 0);

        // 2: eight back-to-back ops
        for (int c = 0; c < 12; c++) begin
            req_valid = c < 8; req_in0 = 16'(c); req_in1 = 16'(c + 1); req_tag = 11'(c);
            if (c < 8) chk("t2_ready", 32'(req_ready), 1);
            if (c >= 3 && c <= 10) begin
                chk("t2_valid", 32'(rsp_valid), 1);
                chk("t2_data", 32'(rsp_data), 32'((c - 3) * (c - 2)));
                chk("t2_tag", 32'(rsp_tag), 32'(c - 3));
            end else chk("t2_idle", 32'(rsp_valid), 0);
            tick();
        end
        req_valid = 1'b0;

        // 3: fill with consumer stalled, then drain while streaming
        rsp_ready = 1'b0; k = 0; issued = 0; popped = 0; sb.delete();
        repeat (8) begin
            req_valid = 1'b1; drive_op(); sb_step("t3_fill");
        end
        chk("t3_issued", 32'(issued), 4);
        chk("t3_ready_full", 32'(req_ready), 0);
        chk("t3_occ_full", 32'(occupancy), 4);
        chk("t3_valid_full", 32'(rsp_valid), 1);
        rsp_ready = 1'b1;
        for (int c = 0; c < 40 && popped < 10; c++) begin
            req_valid = k < 10; drive_op(); sb_step("t3_drain");
        end
        req_valid = 1'b0;
        chk("t3_popped", 32'(popped), 10);
        chk("t3_issued_all", 32'(issued), 10);
        chk("t3_occ_end", 32'(occupancy), 0);
        chk("t3_idle_end", 32'(rsp_valid), 0);

        // 4: truncation corners
        req_valid = 1'b1; req_in0 = 16'hFFFF; req_in1 = 16'hFFFF; req_tag = 11'h7FF;
        tick();
        req_in0 = 16'h0100; req_in1 = 16'h0100; req_tag = 11'h001;
        tick();
        req_valid = 1'b0;
        tick();
        chk("t4_valid_a", 32'(rsp_valid), 1);
        chk("t4_data_a", 32'(rsp_data), 32'h0001);
        chk("t4_tag_a", 32'(rsp_tag), 32'h7FF);
        tick();
        chk("t4_valid_b", 32'(rsp_valid), 1);
        chk("t4_data_b", 32'(rsp_data), 32'h0000);
        chk("t4_tag_b", 32'(rsp_tag), 1);
        tick();
        chk("t4_idle", 32'(rsp_valid), 0);

        // 5: reset while ops are in flight
        req_valid = 1'b1; req_in0 = 16'd2; req_in1 = 16'd3; req_tag = 11'd5;
        chk("t5_ready", 32'(req_ready), 1);
        tick();
        reset = 1'b1; req_in0 = 16'd4; req_in1 = 16'd4; req_tag = 11'd6;
        #1;
        chk("t5_rst_occ", 32'(occupancy), 0);
        chk("t5_rst_ready", 32'(req_ready), 0);
        chk("t5_rst_valid", 32'(rsp_valid), 0);
        @(posedge clock);
        #1;
        reset = 1'b0; req_valid = 1'b0;
        #1;
        chk("t5_ready_back", 32'(req_ready), 1);
        repeat (6) begin
            chk("t5_no_rsp", 32'(rsp_valid), 0);
            tick();
        end
        chk("t5_occ", 32'(occupancy), 0);

        // 6: full FIFO, pop frees a slot next cycle, pointers wrap repeatedly
        rsp_ready = 1'b0; k = 10; issued = 0; popped = 0; sb.delete();
        repeat (8) begin
            req_valid = 1'b1; drive_op(); sb_step("t6_fill");
        end
        chk("t6_occ_full", 32'(occupancy), 4);
        rsp_ready = 1'b1; req_valid = 1'b1; drive_op();
        chk("t6_ready_pop_cycle", 32'(req_ready), 0);
        chk("t6_valid_pop_cycle", 32'(rsp_valid), 1);
        sb_step("t6_first_pop");
        chk("t6_ready_next", 32'(req_ready), 1);
        chk("t6_occ_next", 32'(occupancy), 3);
        for (int c = 0; c < 80 && popped < 16; c++) begin
            req_valid = k < 26; drive_op(); sb_step("t6_stream");
        end
        req_valid = 1'b0;
        chk("t6_popped", 32'(popped), 16);
        chk("t6_sb_empty", 32'(sb.size()), 0);
        chk("t6_occ_end", 32'(occupancy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
